// File: rtl/ibis_affine_mapper_pipe.sv
// ibis_affine_mapper_pipe: 4-stage affine texture-address generator.
// Computes [u v] = M*([x y] - T) with tile-centre bias, then applies the
// stencil / wrap / clamp edge mode for a runtime power-of-two tile size.
// Configuration is shadowed and committed atomically once the pipe drains.
// Optional feature macro: IBIS_AFFINE_MAPPER_MOSAIC_EN (coordinate mosaic).
module ibis_affine_mapper_pipe #(
  parameter int COORD_WIDTH   = 11,
  parameter int FRAC_BITS     = 8,
  parameter int COEF_WIDTH    = 18,
  parameter int TILE_POW2_MAX = 9
) (
  input  logic                           aclk,
  input  logic                           aresetn,
`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
  input  logic [8:0]                     cfg_write,
  input  logic [3:0]                     cfg_mosaic,
`else
  input  logic [7:0]                     cfg_write,
`endif
  input  logic signed [COEF_WIDTH-1:0]   cfg_matrix_a,
  input  logic signed [COEF_WIDTH-1:0]   cfg_matrix_b,
  input  logic signed [COEF_WIDTH-1:0]   cfg_matrix_c,
  input  logic signed [COEF_WIDTH-1:0]   cfg_matrix_d,
  input  logic signed [COEF_WIDTH-1:0]   cfg_translate_x,
  input  logic signed [COEF_WIDTH-1:0]   cfg_translate_y,
  input  logic [3:0]                     cfg_power2,
  input  logic [1:0]                     cfg_mode,
  input  logic                           cfg_commit,
  output logic                           cfg_pending,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [COORD_WIDTH-1:0]         s_x,
  input  logic [COORD_WIDTH-1:0]         s_y,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [2*TILE_POW2_MAX-1:0]     m_address,
  output logic                           m_stencil_test,
  output logic                           m_stencil_step
);

  localparam int XW = COORD_WIDTH + FRAC_BITS + 2;   // translated coordinate
  localparam int PW = XW + COEF_WIDTH;               // full product
  localparam int SW = PW + 2;                        // sum + bias + guard
  localparam int UW = SW - 2 * FRAC_BITS;            // integer texel coordinate
  localparam int IW = $clog2(UW);
  localparam int AW = 2 * TILE_POW2_MAX;
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << FRAC_BITS;

  // Out-of-range tile exponents are folded into the legal range at write time.
  function automatic logic [3:0] coerce_p(input logic [3:0] p);
    logic [3:0] r;
    if (p == 4'd0) r = 4'd1;
    else if (p > 4'(TILE_POW2_MAX)) r = 4'(TILE_POW2_MAX);
    else r = p;
    return r;
  endfunction

  logic signed [COEF_WIDTH-1:0] sh_a_r, sh_b_r, sh_c_r, sh_d_r, sh_tx_r, sh_ty_r;
  logic signed [COEF_WIDTH-1:0] ac_a_r, ac_b_r, ac_c_r, ac_d_r, ac_tx_r, ac_ty_r;
  logic [3:0] sh_p_r, ac_p_r;
  logic [1:0] sh_mode_r, ac_mode_r;

  logic v0_r, v1_r, v2_r;
  logic adv_s, pipe_empty_s;
  logic [COORD_WIDTH-1:0] x_m_s, y_m_s;
  logic signed [XW-1:0] xf_s, yf_s, xf_r, yf_r;
  logic signed [PW-1:0] ax_r, by_r, cx_r, dy_r;
  logic signed [SW-1:0] bias_s, su_s, sv_s, su_r, sv_r;
  logic signed [UW-1:0] u_s, v_s, uo_s, vo_s, tile_s, mask_s;
  logic in_u_s, in_v_s, test_s, step_s;
  logic [AW-1:0] addr_s;

  assign adv_s        = !m_valid || m_ready;
  assign s_ready      = adv_s && !cfg_pending;
  assign pipe_empty_s = !(v0_r || v1_r || v2_r || m_valid);

`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
  logic [3:0] sh_mosaic_r, ac_mosaic_r;
  logic [3:0] mos_n_s;

  // Mosaic: clear the low ac_mosaic bits of each coordinate (saturating count).
  always_comb begin
    mos_n_s = 4'd0;
    if (ac_mosaic_r > 4'(COORD_WIDTH)) mos_n_s = 4'(COORD_WIDTH);
    else mos_n_s = ac_mosaic_r;
    x_m_s = s_x & ({COORD_WIDTH{1'b1}} << mos_n_s);
    y_m_s = s_y & ({COORD_WIDTH{1'b1}} << mos_n_s);
  end

  // Shadow mosaic register, written through mask bit 8.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sh_mosaic_r <= 4'd0;
    else if (cfg_write[8]) sh_mosaic_r <= cfg_mosaic;
  end

  // Active mosaic register, loaded with the rest of the set on commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ac_mosaic_r <= 4'd0;
    else if (cfg_pending && pipe_empty_s) ac_mosaic_r <= sh_mosaic_r;
  end
`else
  assign x_m_s = s_x;
  assign y_m_s = s_y;
`endif

  // Shadow configuration: each field written independently through the mask.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_a_r <= COEF_ONE;  sh_b_r <= '0;  sh_c_r <= '0;  sh_d_r <= COEF_ONE;
      sh_tx_r <= '0;       sh_ty_r <= '0; sh_p_r <= 4'd5; sh_mode_r <= 2'd0;
    end else begin
      if (cfg_write[0]) sh_a_r <= cfg_matrix_a;
      if (cfg_write[1]) sh_b_r <= cfg_matrix_b;
      if (cfg_write[2]) sh_c_r <= cfg_matrix_c;
      if (cfg_write[3]) sh_d_r <= cfg_matrix_d;
      if (cfg_write[4]) sh_tx_r <= cfg_translate_x;
      if (cfg_write[5]) sh_ty_r <= cfg_translate_y;
      if (cfg_write[6]) sh_p_r <= coerce_p(cfg_power2);
      if (cfg_write[7]) sh_mode_r <= cfg_mode;
    end
  end

  // Commit tracking: copy shadow to active only when no beat is in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ac_a_r <= COEF_ONE;  ac_b_r <= '0;  ac_c_r <= '0;  ac_d_r <= COEF_ONE;
      ac_tx_r <= '0;       ac_ty_r <= '0; ac_p_r <= 4'd5; ac_mode_r <= 2'd0;
      cfg_pending <= 1'b0;
    end else if (cfg_pending && pipe_empty_s) begin
      ac_a_r <= sh_a_r;   ac_b_r <= sh_b_r;   ac_c_r <= sh_c_r;  ac_d_r <= sh_d_r;
      ac_tx_r <= sh_tx_r; ac_ty_r <= sh_ty_r; ac_p_r <= sh_p_r;  ac_mode_r <= sh_mode_r;
      cfg_pending <= 1'b0;
    end else if (cfg_commit) begin
      cfg_pending <= 1'b1;
    end
  end

  // S0 translate, S2 bias/sum and S3 edge-mode datapath.
  always_comb begin
    xf_s   = $signed({2'b00, x_m_s, {FRAC_BITS{1'b0}}}) - XW'(ac_tx_r);
    yf_s   = $signed({2'b00, y_m_s, {FRAC_BITS{1'b0}}}) - XW'(ac_ty_r);
    bias_s = SW'(1) << (2 * FRAC_BITS + int'(ac_p_r) - 1);
    su_s   = SW'(ax_r) + SW'(by_r) + bias_s;
    sv_s   = SW'(cx_r) + SW'(dy_r) + bias_s;
    u_s    = $signed(su_r[SW-1:2*FRAC_BITS]);
    v_s    = $signed(sv_r[SW-1:2*FRAC_BITS]);
    tile_s = UW'(1) << ac_p_r;
    mask_s = tile_s - UW'(1);
    in_u_s = !u_s[UW-1] && (u_s < tile_s);
    in_v_s = !v_s[UW-1] && (v_s < tile_s);
    step_s = ~(u_s[IW'(ac_p_r)] ^ v_s[IW'(ac_p_r)]);
    uo_s   = u_s;
    vo_s   = v_s;
    test_s = 1'b1;
    case (ac_mode_r)
      2'd1: begin
        test_s = 1'b1;
      end
      2'd2: begin
        if (u_s[UW-1]) uo_s = '0;
        else if (!in_u_s) uo_s = mask_s;
        else uo_s = u_s;
        if (v_s[UW-1]) vo_s = '0;
        else if (!in_v_s) vo_s = mask_s;
        else vo_s = v_s;
        test_s = 1'b1;
      end
      default: begin
        test_s = in_u_s && in_v_s;
      end
    endcase
    addr_s = (AW'(vo_s & mask_s) << ac_p_r) | AW'(uo_s & mask_s);
  end

  // Stall-all pipeline: every stage advances together when the output can move.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v0_r <= 1'b0; v1_r <= 1'b0; v2_r <= 1'b0; m_valid <= 1'b0;
      xf_r <= '0; yf_r <= '0;
      ax_r <= '0; by_r <= '0; cx_r <= '0; dy_r <= '0;
      su_r <= '0; sv_r <= '0;
      m_address <= '0; m_stencil_test <= 1'b0; m_stencil_step <= 1'b0;
    end else if (adv_s) begin
      v0_r <= s_valid && s_ready;
      xf_r <= xf_s;
      yf_r <= yf_s;
      v1_r <= v0_r;
      ax_r <= PW'(ac_a_r) * PW'(xf_r);
      by_r <= PW'(ac_b_r) * PW'(yf_r);
      cx_r <= PW'(ac_c_r) * PW'(xf_r);
      dy_r <= PW'(ac_d_r) * PW'(yf_r);
      v2_r <= v1_r;
      su_r <= su_s;
      sv_r <= sv_s;
      m_valid <= v2_r;
      m_address <= addr_s;
      m_stencil_test <= test_s;
      m_stencil_step <= step_s;
    end
  end

endmodule

// File: tb/tb_ibis_affine_mapper_pipe.sv
// Scoreboard bench for ibis_affine_mapper_pipe: stimulus pushes hand-computed
// expectations, a separate monitor pops and compares on every output beat.
module tb_ibis_affine_mapper_pipe;

`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
  localparam int WW = 9;
  logic [3:0] cfg_mosaic;
`else
  localparam int WW = 8;
`endif

  typedef struct packed {
    logic [17:0] addr;
    logic        test;
    logic        step;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn;
  logic [WW-1:0] cfg_write;
  logic signed [17:0] cfg_matrix_a, cfg_matrix_b, cfg_matrix_c, cfg_matrix_d;
  logic signed [17:0] cfg_translate_x, cfg_translate_y;
  logic [3:0] cfg_power2;
  logic [1:0] cfg_mode;
  logic cfg_commit, cfg_pending;
  logic s_valid, s_ready;
  logic [10:0] s_x, s_y;
  logic m_valid, m_ready;
  logic [17:0] m_address;
  logic m_stencil_test, m_stencil_step;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  ibis_affine_mapper_pipe dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_write(cfg_write),
`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
    .cfg_mosaic(cfg_mosaic),
`endif
    .cfg_matrix_a(cfg_matrix_a), .cfg_matrix_b(cfg_matrix_b),
    .cfg_matrix_c(cfg_matrix_c), .cfg_matrix_d(cfg_matrix_d),
    .cfg_translate_x(cfg_translate_x), .cfg_translate_y(cfg_translate_y),
    .cfg_power2(cfg_power2), .cfg_mode(cfg_mode),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address),
    .m_stencil_test(m_stencil_test), .m_stencil_step(m_stencil_step)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int addr, input bit t, input bit s);
    exp_t e;
    e.addr = 18'(addr);
    e.test = t;
    e.step = s;
    return e;
  endfunction

  // identity, p=5, stencil: u=x+16, v=y+16, all inside for x,y<16
  function automatic exp_t ident(input int x, input int y);
    return mk((y + 16) * 32 + (x + 16), 1'b1, 1'b1);
  endfunction

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input int mask);
    cfg_write = WW'(mask);
    tick();
    cfg_write = '0;
  endtask

  task automatic send(input int x, input int y, input exp_t e);
    int n;
    s_valid = 1'b1;
    s_x = 11'(x);
    s_y = 11'(y);
    n = 0;
    @(negedge aclk);
    while (!s_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
    else sb.push_back(e);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic commit_wait;
    int n;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 0;
    while (cfg_pending && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (cfg_pending) chk("commit_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every handshaken output beat with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("m_address", 32'(m_address), 32'(e.addr));
          chk("m_stencil_test", 32'(m_stencil_test), 32'(e.test));
          chk("m_stencil_step", 32'(m_stencil_step), 32'(e.step));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; cfg_write = '0; cfg_commit = 1'b0;
    cfg_matrix_a = 18'sh100; cfg_matrix_b = 18'sh0; cfg_matrix_c = 18'sh0;
    cfg_matrix_d = 18'sh100; cfg_translate_x = 18'sh0; cfg_translate_y = 18'sh0;
    cfg_power2 = 4'd5; cfg_mode = 2'd0;
`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
    cfg_mosaic = 4'd0;
`endif
    s_valid = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_address", 32'(m_address), 32'd0);
    chk("rst_stencil_test", 32'(m_stencil_test), 32'd0);
    chk("rst_stencil_step", 32'(m_stencil_step), 32'd0);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    tick();

    // Identity defaults, x=3 y=7 -> {v=23,u=19}; exact 4-cycle latency
    send(3, 7, mk(23 * 32 + 19, 1'b1, 1'b1));
    @(negedge aclk); chk("lat_c1", 32'(m_valid), 32'd0);
    @(negedge aclk); chk("lat_c2", 32'(m_valid), 32'd0);
    @(negedge aclk); chk("lat_c3", 32'(m_valid), 32'd0);
    @(negedge aclk); chk("lat_c4", 32'(m_valid), 32'd1);
    drain();
    tick();

    // Tx=20.0 with empty pipe: commit applies the following cycle
    cfg_translate_x = 18'sh1400;
    wr(32'h10);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    @(negedge aclk); chk("commit_pending_set", 32'(cfg_pending), 32'd1);
    @(negedge aclk); chk("commit_pending_clear", 32'(cfg_pending), 32'd0);
    tick();
    // u=-4, v=32: stencil miss; wrap u=28 v=0; clamp u=0 v=31
    send(0, 16, mk(28, 1'b0, 1'b1));
    cfg_mode = 2'd1; wr(32'h80); commit_wait();
    send(0, 16, mk(28, 1'b1, 1'b1));
    cfg_mode = 2'd2; wr(32'h80); commit_wait();
    send(0, 16, mk(31 * 32 + 0, 1'b1, 1'b1));
    drain();

    // A=2.0: x=10 -> u=36 (outside, u[5]=1 flips step); x=0 -> u=16
    cfg_translate_x = 18'sh0; cfg_mode = 2'd0; cfg_matrix_a = 18'sh200;
    wr(32'h91); commit_wait();
    send(10, 0, mk(16 * 32 + 4, 1'b0, 1'b0));
    send(0, 0, mk(16 * 32 + 16, 1'b1, 1'b1));
    drain();

    // Backpressure: 8 back-to-back beats with m_ready low 5 cycles
    cfg_matrix_a = 18'sh100; wr(32'h01); commit_wait();
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 2 * i, ident(i, 2 * i));
      end
      begin
        int n;
        logic [17:0] held;
        n = 0;
        @(negedge aclk);
        while (!m_valid && n < 50) begin
          @(negedge aclk);
          n++;
        end
        held = m_address;
        chk("stall_first_addr", 32'(held), 32'(16 * 32 + 16));
        repeat (5) begin
          @(negedge aclk);
          chk("stall_m_valid", 32'(m_valid), 32'd1);
          chk("stall_addr_held", 32'(m_address), 32'(held));
          chk("stall_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge aclk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Commit with 3 beats in flight: old matrix for them, new one afterwards
    cfg_matrix_a = 18'sh200; wr(32'h01);
    send(1, 0, ident(1, 0));
    send(2, 0, ident(2, 0));
    send(3, 0, ident(3, 0));
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    @(negedge aclk);
    chk("inflight_pending", 32'(cfg_pending), 32'd1);
    chk("inflight_s_ready", 32'(s_ready), 32'd0);
    send(4, 0, mk(16 * 32 + 24, 1'b1, 1'b1));
    chk("inflight_pending_clear", 32'(cfg_pending), 32'd0);
    drain();

    // p coercion: 0 -> 1 and 15 -> 9; mode 3 behaves as stencil
    cfg_matrix_a = 18'sh100; cfg_power2 = 4'd0; wr(32'h41); commit_wait();
    send(0, 0, mk(3, 1'b1, 1'b1));
    drain();
    cfg_power2 = 4'd15; wr(32'h40); commit_wait();
    send(0, 0, mk(256 * 512 + 256, 1'b1, 1'b1));
    send(300, 0, mk(256 * 512 + 44, 1'b0, 1'b0));
    drain();
    cfg_mode = 2'd3; wr(32'h80); commit_wait();
    send(300, 0, mk(256 * 512 + 44, 1'b0, 1'b0));
    drain();
    cfg_power2 = 4'd5; cfg_mode = 2'd0; wr(32'hC0); commit_wait();

`ifdef IBIS_AFFINE_MAPPER_MOSAIC_EN
    // Mosaic 3: x=13..15 all collapse onto x=8 -> u=24
    cfg_mosaic = 4'd3; wr(32'h100); commit_wait();
    for (int i = 13; i < 16; i++) send(i, 0, mk(16 * 32 + 24, 1'b1, 1'b1));
    drain();
    cfg_mosaic = 4'd0; wr(32'h100); commit_wait();
`endif

    // Reset mid-stream: in-flight beats and a pending commit are discarded
    cfg_matrix_a = 18'sh200; wr(32'h01); commit_wait();
    m_ready = 1'b0;
    s_valid = 1'b1; s_x = 11'd5; s_y = 11'd5;
    repeat (3) tick();
    s_valid = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (3) tick();
    chk("pre_reset_m_valid", 32'(m_valid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_pending", 32'(cfg_pending), 32'd0);
    chk("async_rst_addr", 32'(m_address), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_ready = 1'b1;
    tick();
    send(3, 7, mk(23 * 32 + 19, 1'b1, 1'b1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
